inst_issue_queue: RTL and testbench

- Instruction supply stage sitting directly upstream of the 3-stage add/sub/and pipeline.
- Accepts 8-bit instructions from an instruction source over a valid/ready handshake and buffers them in a small FIFO.
- Presents exactly one instruction per cycle on the pipeline's inst input. Substitutes a NOP when the queue is empty, held or flushed.
- Keeps an issue counter for the verification wrapper and for performance checks.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/iq_storage.sv | 61 ++++++
 rtl/inst_issue_queue.sv | 73 +++++++
 tb/tb_inst_issue_queue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : instruction format and opcodes shared by the add/sub/and pipe
// Revision : 1.0
// ============================================================================
package pipe_pkg;
  localparam int OP_W   = 2;
  localparam int REG_W  = 2;
  localparam int INST_W = 8;

  localparam logic [OP_W-1:0] OP_NOP = 2'b00;
  localparam logic [OP_W-1:0] OP_ADD = 2'b01;
  localparam logic [OP_W-1:0] OP_SUB = 2'b10;
  localparam logic [OP_W-1:0] OP_AND = 2'b11;

  localparam logic [INST_W-1:0] NOP_INST = 8'h00;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
  } inst_t;
endpackage
`default_nettype wire

// File: rtl/iq_storage.sv
`default_nettype none
// ============================================================================
// iq_storage : DEPTH-entry circular instruction buffer with occupancy count
// Revision   : 1.0
// ============================================================================
module iq_storage
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  inst_t                        wr_data,
  output inst_t                        head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH+1);

  inst_t               r_mem [DEPTH];
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [CNT_BITS-1:0] r_count;

  // Full and empty share pointer equality; the count alone tells them apart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_BITS'(1);
        2'b01:   r_count <= r_count - CNT_BITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= wr_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    r_count <= CNT_BITS'(DEPTH));
  a_ptr_count: assert property (@(posedge clk) disable iff (!rst)
    PTR_W'(r_wr_ptr - r_rd_ptr) == r_count[PTR_W-1:0]);
endmodule
`default_nettype wire

// File: rtl/inst_issue_queue.sv
`default_nettype none
// ============================================================================
// inst_issue_queue : buffered instruction supply with NOP fill and issue count
// Revision         : 1.0
// ============================================================================
module inst_issue_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DROP_NOPS = 1,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [INST_W-1:0]           in_inst,
  output logic                        in_ready,
  input  logic                        hold,
  input  logic                        flush,
  output logic [INST_W-1:0]           inst,
  output logic                        inst_issued,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic [CNT_W-1:0]            issue_cnt
);
  localparam int CNT_BITS = $clog2(DEPTH+1);

  inst_t               w_in;
  inst_t               w_head;
  logic                w_is_nop;
  logic                w_push;
  logic                w_store;
  logic                w_pop;
  logic [CNT_BITS-1:0] w_count;
  logic [CNT_W-1:0]    r_issue_cnt;

  assign w_in     = inst_t'(in_inst);
  assign w_is_nop = (DROP_NOPS != 0) && (w_in.op == OP_NOP);

  // Ready depends on registered occupancy only, so a full queue stalls even while popping.
  assign in_ready = (w_count != CNT_BITS'(DEPTH)) && !flush && rst;
  assign w_push   = in_valid && in_ready && !flush;
  assign w_store  = w_push && !w_is_nop;
  assign w_pop    = (w_count != '0) && !hold && !flush;

  iq_storage #(
    .DEPTH   (DEPTH)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .push    (w_store),
    .pop     (w_pop),
    .flush   (flush),
    .wr_data (w_in),
    .head    (w_head),
    .count   (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_issue_cnt <= '0;
    else if (w_pop) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
  end

  assign inst        = w_pop ? w_head : NOP_INST;
  assign inst_issued = w_pop;
  assign count       = w_count;
  assign issue_cnt   = r_issue_cnt;

  a_issue_nonempty: assert property (@(posedge clk) disable iff (!rst)
    inst_issued |-> (w_count != '0));
  a_idle_is_nop: assert property (@(posedge clk) disable iff (!rst)
    !inst_issued |-> (inst == NOP_INST));
endmodule
`default_nettype wire

// File: tb/tb_inst_issue_queue.sv
`default_nettype none
// ============================================================================
// tb_inst_issue_queue : vector table plus queue scoreboard for inst_issue_queue
// Revision            : 1.0
// ============================================================================
module tb_inst_issue_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_inst;
  logic        in_ready;
  logic        hold;
  logic        flush;
  logic [7:0]  inst;
  logic        inst_issued;
  logic [2:0]  count;
  logic [15:0] issue_cnt;

  int checks   = 0;
  int failures = 0;

  inst_issue_queue #(
    .DEPTH       (4),
    .DROP_NOPS   (1),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .in_valid    (in_valid),
    .in_inst     (in_inst),
    .in_ready    (in_ready),
    .hold        (hold),
    .flush       (flush),
    .inst        (inst),
    .inst_issued (inst_issued),
    .count       (count),
    .issue_cnt   (issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: stored instructions queue up here and must leave in order.
  logic [7:0]  sb_q[$];
  logic [15:0] m_cnt = '0;

  always @(negedge clk) begin
    logic e_ready, e_pop, e_store;
    logic [7:0] e_inst;
    if (!rst_n) begin
      sb_q.delete();
      m_cnt = '0;
    end
    e_ready = rst_n && (sb_q.size() != 4) && !flush;
    e_pop   = rst_n && (sb_q.size() != 0) && !hold && !flush;
    e_store = in_valid && e_ready && (in_inst[7:6] != 2'b00);
    e_inst  = e_pop ? sb_q[0] : 8'h00;
    check("sb_ready",  {31'd0, in_ready},    {31'd0, e_ready});
    check("sb_issued", {31'd0, inst_issued}, {31'd0, e_pop});
    check("sb_inst",   {24'd0, inst},        {24'd0, e_inst});
    check("sb_count",  {29'd0, count},       32'(sb_q.size()));
    check("sb_icnt",   {16'd0, issue_cnt},   {16'd0, m_cnt});
    if (rst_n) begin
      if (flush) sb_q.delete();
      else begin
        if (e_pop)   void'(sb_q.pop_front());
        if (e_store) sb_q.push_back(in_inst);
      end
      if (e_pop) m_cnt = m_cnt + 16'd1;
    end
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic [7:0]  e_inst;
    logic        e_iss;
    logic [2:0]  e_cnt;
    logic [15:0] e_icnt;
    logic        e_rdy;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bit done = 0;
    in_valid = 1'b1;
    in_inst  = d;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (count == 3'd0) done = 1;
      tick();
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int waited;
    logic [15:0] start_cnt;
    bit got;

    tbl[0] = '{1'b1, 8'h41, 8'h00, 1'b0, 3'd0, 16'd0, 1'b1};
    tbl[1] = '{1'b1, 8'h86, 8'h41, 1'b1, 3'd1, 16'd0, 1'b1};
    tbl[2] = '{1'b1, 8'hC7, 8'h86, 1'b1, 3'd1, 16'd1, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 8'hC7, 1'b1, 3'd1, 16'd2, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 16'd3, 1'b1};
    tbl[5] = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 16'd3, 1'b1};
    tbl[6] = '{1'b1, 8'h3F, 8'h00, 1'b0, 3'd0, 16'd3, 1'b1};
    tbl[7] = '{1'b1, 8'h55, 8'h00, 1'b0, 3'd0, 16'd3, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 8'h55, 1'b1, 3'd1, 16'd3, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 16'd4, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_inst = 8'h00; hold = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic issue and NOP-drop sequence.
    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].v;
      in_inst  = tbl[i].d;
      @(negedge clk);
      check($sformatf("tbl%0d_inst", i),   {24'd0, inst},        {24'd0, tbl[i].e_inst});
      check($sformatf("tbl%0d_issued", i), {31'd0, inst_issued}, {31'd0, tbl[i].e_iss});
      check($sformatf("tbl%0d_count", i),  {29'd0, count},       {29'd0, tbl[i].e_cnt});
      check($sformatf("tbl%0d_icnt", i),   {16'd0, issue_cnt},   {16'd0, tbl[i].e_icnt});
      check($sformatf("tbl%0d_ready", i),  {31'd0, in_ready},    {31'd0, tbl[i].e_rdy});
      tick();
    end
    in_valid = 1'b0;

    // Fill under hold; fifth waits until one cycle after hold is released.
    hold = 1'b1;
    send(8'h41); send(8'h52); send(8'h63); send(8'h74);
    in_valid = 1'b1; in_inst = 8'hE5;
    @(negedge clk);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    check("full_count", {29'd0, count},    32'd4);
    tick();
    @(negedge clk);
    tick();
    hold = 1'b0;
    waited = 0; got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1; else waited++;
      tick();
    end
    in_valid = 1'b0;
    check("accept_ok",    {31'd0, got}, 32'd1);
    check("accept_delay", 32'(waited),  32'd1);
    drain();

    // Flush with three entries queued and the source still valid.
    hold = 1'b1;
    send(8'h71); send(8'h82); send(8'h93);
    start_cnt = m_cnt;
    hold = 1'b0; flush = 1'b1; in_valid = 1'b1; in_inst = 8'hA4;
    @(negedge clk);
    check("flush_ready",  {31'd0, in_ready},    32'd0);
    check("flush_inst",   {24'd0, inst},        32'd0);
    check("flush_issued", {31'd0, inst_issued}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_count", {29'd0, count},     32'd0);
    check("flush_icnt",  {16'd0, issue_cnt}, {16'd0, start_cnt});
    tick();

    // Steady push/pop at occupancy 1 across several pointer wraps.
    send(8'hD1);
    start_cnt = m_cnt;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_inst  = {2'(i % 3 + 1), 6'(i)};
      @(negedge clk);
      check($sformatf("steady%0d_count", i), {29'd0, count}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("steady_icnt", {16'd0, issue_cnt}, {16'd0, start_cnt + 16'd20});
    tick();
    drain();

    // Asynchronous reset with two entries queued and the head on inst.
    hold = 1'b1;
    send(8'hB1); send(8'hC2);
    hold = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_inst",  {24'd0, inst},      32'd0);
    check("rst_count", {29'd0, count},     32'd0);
    check("rst_icnt",  {16'd0, issue_cnt}, 32'd0);
    check("rst_ready", {31'd0, in_ready},  32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    send(8'h9A);
    @(negedge clk);
    check("post_rst_inst",   {24'd0, inst},        32'h9A);
    check("post_rst_issued", {31'd0, inst_issued}, 32'd1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
